// File: rtl/fp_div_seq.sv
// Sequential IEEE-754 single-precision divider.
// Restoring radix-2 core, one quotient bit per clock, valid/ready handshake.
package fp_div_pkg;
  typedef enum logic [2:0] {
    IEEE_near,
    IEEE_zero,
    IEEE_pinf,
    IEEE_ninf,
    near_up,
    away_zero
  } round_values;
endpackage

module fp_div_seq
  import fp_div_pkg::*;
#(
  parameter round_values round = IEEE_near
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] z,
  output logic [7:0]  status,
  output logic        out_valid,
  input  logic        out_ready
);

  typedef enum logic [1:0] {IDLE, DIV, NORM, DONE} state_t;

  state_t            state_q;
  logic [4:0]        cnt_q;
  logic [24:0]       rem_q;
  logic [23:0]       mb_q;
  logic [25:0]       quo_q;
  logic signed [9:0] exp_q;
  logic              sign_q;
  logic              nan_q;
  logic              dz_q;
  logic              inf_q;
  logic              zero_q;
  logic [31:0]       z_q;
  logic [7:0]        st_q;
  logic              ov_q;

  logic [7:0]  ea, eb;
  logic [22:0] fa, fb;
  logic        a_zero, b_zero;
  logic        a_inf, b_inf;
  logic        a_nan, b_nan;
  logic        nan_d;

  assign ea = a[30:23];
  assign eb = b[30:23];
  assign fa = a[22:0];
  assign fb = b[22:0];

  // Denormals have a zero exponent field and are flushed to signed zero.
  assign a_zero = (ea == 8'h00);
  assign b_zero = (eb == 8'h00);
  assign a_inf  = (ea == 8'hFF) && (fa == 23'd0);
  assign b_inf  = (eb == 8'hFF) && (fb == 23'd0);
  assign a_nan  = (ea == 8'hFF) && (fa != 23'd0);
  assign b_nan  = (eb == 8'hFF) && (fb != 23'd0);

  assign nan_d = a_nan | b_nan
               | (a_zero & b_zero)
               | (a_inf & b_inf);

  logic        ge;
  logic [24:0] diff;
  logic [24:0] rsel;

  assign ge   = rem_q >= {1'b0, mb_q};
  assign diff = rem_q - {1'b0, mb_q};
  assign rsel = ge ? diff : rem_q;

  logic [23:0]       man;
  logic              g, r, s;
  logic              inx;
  logic              inc;
  logic              to_inf;
  logic signed [9:0] e_n;
  logic signed [9:0] e_r;
  logic [24:0]       man_r;
  logic [22:0]       frac;
  logic              ovf;
  logic              unf;
  logic [31:0]       z_d;
  logic [7:0]        st_d;

  // A quotient below 1 has its leading one one place lower.
  always_comb begin
    man = quo_q[24:1];
    g   = quo_q[0];
    r   = 1'b0;
    e_n = exp_q - 10'sd1;
    if (quo_q[25]) begin
      man = quo_q[25:2];
      g   = quo_q[1];
      r   = quo_q[0];
      e_n = exp_q;
    end
  end

  assign s   = |rem_q;
  assign inx = g | r | s;

  always_comb begin
    inc    = 1'b0;
    to_inf = 1'b1;
    case (round)
      IEEE_near: inc = g & (r | s | man[0]);
      IEEE_zero: to_inf = 1'b0;
      IEEE_pinf: begin
        inc    = inx & ~sign_q;
        to_inf = ~sign_q;
      end
      IEEE_ninf: begin
        inc    = inx & sign_q;
        to_inf = sign_q;
      end
      near_up:   inc = g;
      away_zero: inc = inx;
      default:   inc = 1'b0;
    endcase
  end

  assign man_r = {1'b0, man} + {24'd0, inc};
  assign frac  = man_r[24] ? man_r[23:1] : man_r[22:0];
  assign e_r   = e_n + $signed({9'd0, man_r[24]});
  assign ovf   = e_r >= 10'sd255;
  assign unf   = e_r <= 10'sd0;

  always_comb begin
    z_d  = {sign_q, e_r[7:0], frac};
    st_d = {2'b00, inx, 5'b00000};
    if (nan_q) begin
      z_d  = 32'h7FC00000;
      st_d = 8'h04;
    end else if (dz_q) begin
      z_d  = {sign_q, 8'hFF, 23'd0};
      st_d = 8'h42;
    end else if (inf_q) begin
      z_d  = {sign_q, 8'hFF, 23'd0};
      st_d = 8'h02;
    end else if (zero_q) begin
      z_d  = {sign_q, 31'd0};
      st_d = 8'h01;
    end else if (unf) begin
      z_d  = {sign_q, 31'd0};
      st_d = 8'h29;
    end else if (ovf) begin
      z_d  = to_inf ? {sign_q, 8'hFF, 23'd0}
                    : {sign_q, 8'hFE, 23'h7FFFFF};
      st_d = to_inf ? 8'h32 : 8'h30;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
      rem_q   <= 25'd0;
      mb_q    <= 24'd0;
      quo_q   <= 26'd0;
      exp_q   <= 10'sd0;
      sign_q  <= 1'b0;
      nan_q   <= 1'b0;
      dz_q    <= 1'b0;
      inf_q   <= 1'b0;
      zero_q  <= 1'b0;
      z_q     <= 32'd0;
      st_q    <= 8'd0;
      ov_q    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            rem_q   <= {2'b01, fa};
            mb_q    <= {1'b1, fb};
            quo_q   <= 26'd0;
            exp_q   <= $signed({2'b00, ea})
                     - $signed({2'b00, eb})
                     + 10'sd127;
            sign_q  <= a[31] ^ b[31];
            nan_q   <= nan_d;
            dz_q    <= ~nan_d & b_zero & ~a_zero & ~a_inf;
            inf_q   <= ~nan_d & a_inf;
            zero_q  <= ~nan_d & (a_zero | b_inf);
            cnt_q   <= 5'd25;
            state_q <= DIV;
          end
        end
        DIV: begin
          rem_q <= rsel << 1;
          quo_q <= {quo_q[24:0], ge};
          if (cnt_q == 5'd0) begin
            state_q <= NORM;
          end else begin
            cnt_q <= cnt_q - 5'd1;
          end
        end
        NORM: begin
          z_q     <= z_d;
          st_q    <= st_d;
          ov_q    <= 1'b1;
          state_q <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            ov_q    <= 1'b0;
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign z         = z_q;
  assign status    = st_q;
  assign out_valid = ov_q;

endmodule

// File: doc/fp_div_seq.md
FP_DIV_SEQ -- requirements
Module: fp_div_seq

Interface
REQ-001 Parameter: round, type round_values, default IEEE_near, selects the rounding mode (IEEE_near, IEEE_zero, IEEE_pinf, IEEE_ninf, near_up, away_zero).
REQ-002 clk  input  1  clock; all state changes on the posedge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 a  input  32  IEEE-754 single-precision dividend.
REQ-005 b  input  32  IEEE-754 single-precision divisor.
REQ-006 in_valid  input  1  a and b are valid this cycle.
REQ-007 in_ready  output  1  block can accept operands.
REQ-008 z  output  32  quotient a / b.
REQ-009 status  output  8  flags: [0] zero, [1] inf, [2] nan, [3] tiny, [4] huge, [5] inexact, [6] div_by_zero, [7] reserved (always 0).
REQ-010 out_valid  output  1  z and status are valid.
REQ-011 out_ready  input  1  consumer accepts the result.

Function
REQ-012 FSM states SHALL be IDLE, DIV, NORM and DONE; in_ready SHALL be 1 only in IDLE.
REQ-013 IDLE: when in_valid is 1, a and b SHALL be captured and unpacked, iteration counter set to 25, next state DIV; otherwise the FSM stays in IDLE.
REQ-014 DIV: one restoring radix-2 quotient bit per clock, 26 bits total (24 significand + guard + round); counter decrements each cycle; when counter reaches 0, next state NORM.
REQ-015 Sticky bit SHALL be the OR-reduction of the final partial remainder.
REQ-016 NORM (1 cycle): normalize, round, detect exceptions, register z and status, next state DONE.
REQ-017 DONE: out_valid = 1; z and status SHALL be held stable until out_ready = 1, then next state IDLE.
REQ-018 Latency: the accept edge is T0; out_valid SHALL be 1 in the cycle after edge T27; latency is fixed and applies to special operands as well.
REQ-019 Throughput: at most one operation in flight; the next accept can occur no earlier than the cycle after the out_ready handshake.
REQ-020 Sign: sign(z) = sign(a) XOR sign(b) for all non-NaN results.
REQ-021 Exponent: e = ea - eb + 127, computed in a signed 10-bit intermediate.
REQ-022 Normalization: if the quotient 1.ma/1.mb < 1, shift left by 1 and apply e - 1.
REQ-023 Denormal inputs SHALL be treated as zero with sign preserved.
REQ-024 Underflow (e <= 0 after rounding) SHALL give a signed zero with tiny=1, inexact=1 and zero=1.
REQ-025 Overflow (e >= 255 after rounding) SHALL set huge=1 and inexact=1; the result is inf or max-normal (0x7F7FFFFF with sign) according to the rounding mode toward/away from the sign.
REQ-026 Rounding SHALL use guard/round/sticky per the round parameter; inexact = guard OR round OR sticky; a mantissa carry-out SHALL increment e.
REQ-027 NaN input, 0/0 or inf/inf SHALL give z = 0x7FC00000 with nan=1.
REQ-028 Finite nonzero / 0 SHALL give signed inf with inf=1 and div_by_zero=1.
REQ-029 inf / finite SHALL give signed inf with inf=1.
REQ-030 finite / inf and 0 / nonzero-finite SHALL give signed zero with zero=1.
REQ-031 Exact results SHALL have inexact=0; zero and inf flags SHALL also be set when a normal path produces those values.
REQ-032 in_valid is ignored outside IDLE; a, b, in_valid and out_ready SHALL carry no combinational path to any output.

Reset
REQ-033 With rst = 1 at a posedge, the block SHALL go to IDLE, clear the counter, z = 0, status = 0 and out_valid = 0; in_ready = 1 from the next cycle.
REQ-034 Reset SHALL take priority over every state, including mid-DIV and DONE; an aborted operation produces no output.

Verification
REQ-035 a=0x40C00000, b=0x40000000 (6/2) -> z=0x40400000, status=0x00, out_valid after exactly 27 edges following the accept.
REQ-036 a=0x3F800000, b=0x40400000 (1/3) -> IEEE_near: z=0x3EAAAAAB, status=0x20; IEEE_zero: z=0x3EAAAAAA, status=0x20.
REQ-037 1/0 (0x3F800000 / 0x00000000) -> z=0x7F800000, status=0x42; 0/0 -> z=0x7FC00000, status=0x04.
REQ-038 a=0x7F000000, b=0x3E800000 (overflow) -> z=0x7F800000, status=0x32 (inf, huge, inexact) with IEEE_near; a=0x00800000, b=0x40000000 -> z=0x00000000, status=0x29.
REQ-039 out_ready held 0 for 5 cycles in DONE -> z, status and out_valid stable, in_ready=0; in_valid pulsed during DONE is not captured; the next operation is accepted only after the handshake.
REQ-040 rst pulsed at DIV cycle 10 -> out_valid stays 0, in_ready=1 the next cycle, and a following 6/2 completes with the correct 27-edge latency.
